noc_rr_port_arbiter: RTL and testbench
======================================

Name: noc_rr_port_arbiter

Overview:
- Clocked output-port allocator for one router output in the NoC SNN accelerator.
- Shares one output link among N input requesters: the N/S/E/W router inputs plus the local PE.
- Uses round-robin priority and wormhole packet locking: a granted input keeps the output until its tail flit is accepted.
- Also provides per-packet length policing and grant visibility for the router crossbar.

Parameters:
- N, 5, number of requesters (index 0..N-1).
- FLIT_W, 32, flit payload width in bits.
- MAX_PKT, 16, maximum flits per packet before forced release (must be ≥1).
- IDX_W, 3, width of grant index; must satisfy 2**IDX_W ≥ N.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N  per-requester flit valid.
- req_flit  input  N*FLIT_W  packed flits; requester i occupies bits [i*FLIT_W +: FLIT_W].
- req_tail  input  N  per-requester tail marker for the presented flit.
- req_ready  output  N  per-requester accept; one-hot or zero.
- out_valid  output  1  output flit valid.
- out_flit  output  FLIT_W  output flit.
- out_tail  output  1  output tail marker.
- out_ready  input  1  downstream accept.
- grant_valid  output  1  an input currently holds the output.
- grant_idx  output  IDX_W  index of current holder; 0 when grant_valid=0.
- err_pkt_len  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, rr_ptr=0, grant_idx=0, grant_valid=0, flit_cnt=0, err_pkt_len=0. Combinational outputs then read req_ready=0, out_valid=0, out_flit=0, out_tail=0.
- Reset mid-packet drops the lock immediately. No flit is accepted in the reset cycle. The partial packet is not completed.
- Transfer rule: a flit moves only when out_valid & out_ready. Requester i sees req_ready[i]=1 only while it is the granted holder.
- State IDLE:
  - No flit forwarded; out_valid=0, req_ready=0.
  - If any req_valid bit is set, the winner is the first index j with req_valid[j]=1, scanning rr_ptr, rr_ptr+1, … mod N.
  - Next cycle: state=LOCKED, grant_idx=j, grant_valid=1, flit_cnt=0.
  - If no request, remain IDLE.
- State LOCKED (holder g):
  - out_valid=req_valid[g], out_flit=req_flit[g], out_tail=req_tail[g], req_ready[g]=out_ready.
  - This path is combinational: zero added latency per flit.
  - On each transfer, flit_cnt increments.
  - Transfer with out_tail=1: next state=IDLE, grant_valid=0, grant_idx=0, rr_ptr=(g+1) mod N.
  - Transfer with out_tail=0 and flit_cnt==MAX_PKT-1: forced release. Next state=IDLE, rr_ptr=(g+1) mod N, err_pkt_len=1 for exactly one cycle.
  - Holder deasserting req_valid mid-packet (bubble): grant is held; no timeout.
- Latency: first flit of a packet transfers no earlier than 1 cycle after its request is first seen in IDLE. Each packet release costs exactly one IDLE bubble cycle before the next grant.
- Fairness: with all N requesting continuously, grants rotate 0,1,…,N-1,0. No requester waits more than N-1 packets.
- Single-flit packet (tail on first flit): lock held one transfer only.
- Requests from non-holders during LOCKED are ignored; they do not affect rr_ptr.
- rr_ptr wraps from N-1 to 0.
- flit_cnt width is sufficient for MAX_PKT. It never wraps, because release occurs at MAX_PKT.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req_valid=0 → all outputs 0, grant_valid=0. Then assert req_valid=5'b00100 → grant_idx=2, grant_valid=1 on the next cycle.
- Round-robin rotation: all 5 inputs each send 2-flit packets continuously, out_ready=1 → grant order 0,1,2,3,4,0. Each packet takes 2 transfer cycles plus 1 bubble, so 3 cycles per packet.
- Wormhole lock: input 1 sends 4-flit packet while input 3 requests → out_flit carries only input 1 data for 4 transfers, req_ready[3]=0 throughout. Input 3 is granted after the tail + 1 bubble cycle.
- Backpressure: holder 4 mid-packet, out_ready=0 for 3 cycles → out_flit stable, req_ready[4]=0, flit_cnt unchanged. Transfer resumes when out_ready=1.
- Length policing (MAX_PKT=16): input 0 sends 20 flits with no tail → exactly 16 transfers, err_pkt_len pulses once, grant moves to next requester, rr_ptr=1.
- Reset mid-packet: rst asserted after 2 of 5 flits from input 2 → grant_valid=0 and req_ready=0 next cycle, rr_ptr=0. After deassert with requests 2 and 0 present, input 0 wins.

Source files
------------

// File: rtl/noc_rr_port_arbiter.sv
// Round-robin output-port allocator with wormhole locking for one NoC router output.
// The holder's flit path is purely combinational; arbitration and locking state are registered.

module noc_rr_lane #(
    parameter int FLIT_W = 32
) (
    input  logic              sel_i,
    input  logic              req_valid_i,
    input  logic [FLIT_W-1:0] req_flit_i,
    input  logic              req_tail_i,
    input  logic              out_ready_i,
    output logic              req_ready_o,
    output logic              valid_o,
    output logic [FLIT_W-1:0] flit_o,
    output logic              tail_o
);
    // Non-selected lanes drive zeros so the top can OR-reduce without a wide mux.
    assign req_ready_o = sel_i & out_ready_i;
    assign valid_o     = sel_i & req_valid_i;
    assign flit_o      = sel_i ? req_flit_i : '0;
    assign tail_o      = sel_i & req_tail_i;
endmodule

module noc_rr_port_arbiter #(
    parameter int N       = 5,
    parameter int FLIT_W  = 32,
    parameter int MAX_PKT = 16,
    parameter int IDX_W   = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N-1:0]        req_valid_i,
    input  logic [N*FLIT_W-1:0] req_flit_i,
    input  logic [N-1:0]        req_tail_i,
    output logic [N-1:0]        req_ready_o,
    output logic                out_valid_o,
    output logic [FLIT_W-1:0]   out_flit_o,
    output logic                out_tail_o,
    input  logic                out_ready_i,
    output logic                grant_valid_o,
    output logic [IDX_W-1:0]    grant_idx_o,
    output logic                err_pkt_len_o
);
    localparam int CNT_W = $clog2(MAX_PKT + 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                          state_q, state_d;
    logic   [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic   [IDX_W-1:0]              grant_idx_q, grant_idx_d;
    logic   [CNT_W-1:0]              flit_cnt_q, flit_cnt_d;
    logic                            err_q, err_d;

    logic                            locked;
    logic   [N-1:0]                  lane_valid;
    logic   [N-1:0]                  lane_tail;
    logic   [N-1:0][FLIT_W-1:0]      lane_flit;
    logic                            xfer;
    logic                            at_limit;
    logic   [IDX_W-1:0]              next_ptr;
    logic                            win_found;
    logic   [IDX_W-1:0]              win_idx;
    int                              j;

    // Gating with rst_i keeps a flit from being accepted in the reset cycle itself.
    assign locked = (state_q == LOCKED) && !rst_i;

    for (genvar i = 0; i < N; i++) begin : g_lane
        noc_rr_lane #(.FLIT_W(FLIT_W)) u_lane (
            .sel_i       (locked && (grant_idx_q == IDX_W'(i))),
            .req_valid_i (req_valid_i[i]),
            .req_flit_i  (req_flit_i[i*FLIT_W +: FLIT_W]),
            .req_tail_i  (req_tail_i[i]),
            .out_ready_i (out_ready_i),
            .req_ready_o (req_ready_o[i]),
            .valid_o     (lane_valid[i]),
            .flit_o      (lane_flit[i]),
            .tail_o      (lane_tail[i])
        );
    end

    always_comb begin
        out_flit_o = '0;
        for (int i = 0; i < N; i++) out_flit_o = out_flit_o | lane_flit[i];
    end

    assign out_valid_o   = |lane_valid;
    assign out_tail_o    = |lane_tail;
    assign grant_valid_o = (state_q == LOCKED);
    assign grant_idx_o   = grant_idx_q;
    assign err_pkt_len_o = err_q;

    assign xfer     = out_valid_o & out_ready_i;
    assign at_limit = (flit_cnt_q == CNT_W'(MAX_PKT - 1));
    assign next_ptr = (grant_idx_q == IDX_W'(N - 1)) ? '0 : grant_idx_q + IDX_W'(1);

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N) j = j - N;
            if (!win_found && req_valid_i[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        flit_cnt_d  = flit_cnt_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = LOCKED;
                    grant_idx_d = win_idx;
                    flit_cnt_d  = '0;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    flit_cnt_d = flit_cnt_q + CNT_W'(1);
                    if (out_tail_o || at_limit) begin
                        state_d     = IDLE;
                        grant_idx_d = '0;
                        rr_ptr_d    = next_ptr;
                        flit_cnt_d  = '0;
                        err_d       = !out_tail_o;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            flit_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            flit_cnt_q  <= flit_cnt_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_noc_rr_port_arbiter.sv
// Bench for noc_rr_port_arbiter: per-requester flit sources, an expected-flit queue
// checked on every transfer, and a table of arbitration vectors.

module tb_noc_rr_port_arbiter;
    localparam int N       = 5;
    localparam int FLIT_W  = 32;
    localparam int MAX_PKT = 16;
    localparam int IDX_W   = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N*FLIT_W-1:0] req_flit;
    logic [N-1:0]        req_tail;
    logic [N-1:0]        req_ready;
    logic                out_valid;
    logic [FLIT_W-1:0]   out_flit;
    logic                out_tail;
    logic                out_ready;
    logic                grant_valid;
    logic [IDX_W-1:0]    grant_idx;
    logic                err_pkt_len;

    noc_rr_port_arbiter #(.N(N), .FLIT_W(FLIT_W), .MAX_PKT(MAX_PKT), .IDX_W(IDX_W)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_flit_i(req_flit),
        .req_tail_i(req_tail), .req_ready_o(req_ready), .out_valid_o(out_valid),
        .out_flit_o(out_flit), .out_tail_o(out_tail), .out_ready_i(out_ready),
        .grant_valid_o(grant_valid), .grant_idx_o(grant_idx), .err_pkt_len_o(err_pkt_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           pre;
        logic [N-1:0] mask;
        int           exp;
    } vec_t;

    logic [FLIT_W:0] src_mem [N][32];
    int              src_len [N];
    int              src_pos [N];
    logic [FLIT_W:0] exp_q [$];
    int              glog [$];
    logic [N-1:0]    acc;
    logic            gv_prev = 1'b0;
    int              n_checks = 0;
    int              n_fail = 0;
    int              err_seen = 0;
    int              onehot_viol = 0;
    int              ncyc;

    function automatic logic [FLIT_W:0] mk(int s, int id, int k, bit t);
        return {t, 8'(s), 8'(id), 16'(k)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive();
        req_valid = '0;
        req_flit  = '0;
        req_tail  = '0;
        for (int i = 0; i < N; i++) begin
            if (src_pos[i] < src_len[i]) begin
                req_valid[i]                  = 1'b1;
                req_flit[i*FLIT_W +: FLIT_W]  = src_mem[i][src_pos[i]][FLIT_W-1:0];
                req_tail[i]                   = src_mem[i][src_pos[i]][FLIT_W];
            end
        end
    endtask

    task automatic add_pkt(input int s, input int n, input bit tl, input int id, input bit to_exp);
        for (int k = 0; k < n; k++) begin
            src_mem[s][src_len[s]] = mk(s, id, k, tl && (k == n - 1));
            if (to_exp) exp_q.push_back(src_mem[s][src_len[s]]);
            src_len[s]++;
        end
    endtask

    // One clock: observe at negedge, then update sources just after the rising edge.
    task automatic step();
        logic [N-1:0]    gmask;
        logic [FLIT_W:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_flit", {out_tail, out_flit}, 0);
            else begin
                e = exp_q.pop_front();
                check("flit", {out_tail, out_flit}, e);
            end
        end
        gmask = grant_valid ? (N'(1) << grant_idx) : '0;
        if ((req_ready & ~gmask) != '0) onehot_viol++;
        if (err_pkt_len) err_seen++;
        if (grant_valid && !gv_prev) glog.push_back(int'(grant_idx));
        gv_prev = grant_valid;
        acc = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i] && src_pos[i] < src_len[i]) src_pos[i]++;
        drive();
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        drive();
        step();
        step();
        rst = 1'b0;
        glog.delete();
    endtask

    task automatic run_until_empty(input int budget, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 0);
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{-1, 5'b00100, 2};
        vecs[1] = '{-1, 5'b11111, 0};
        vecs[2] = '{-1, 5'b11000, 3};
        vecs[3] = '{ 1, 5'b00011, 0};
        vecs[4] = '{ 1, 5'b00110, 2};
        vecs[5] = '{ 3, 5'b01001, 0};
        vecs[6] = '{ 3, 5'b10001, 4};
        vecs[7] = '{ 4, 5'b10010, 1};
        vecs[8] = '{ 2, 5'b01010, 3};
        vecs[9] = '{ 0, 5'b00001, 0};

        rst = 1'b1;
        out_ready = 1'b1;
        clear_src();
        drive();
        @(posedge clk);
        #1;

        // Reset state with no requests.
        rst = 1'b1;
        step();
        step();
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_flit", out_flit, 0);
        check("rst_out_tail", out_tail, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_err", err_pkt_len, 0);
        rst = 1'b0;

        // Arbitration table: optional single-flit packet to move rr_ptr, then a request mask.
        foreach (vecs[v]) begin
            do_reset();
            out_ready = 1'b1;
            if (vecs[v].pre >= 0) begin
                add_pkt(vecs[v].pre, 1, 1'b1, 9, 1'b1);
                drive();
                step();
                step();
                check("pre_pkt_done", 64'(exp_q.size()), 0);
            end
            out_ready = 1'b0;
            for (int i = 0; i < N; i++) if (vecs[v].mask[i]) add_pkt(i, 1, 1'b1, 7, 1'b0);
            drive();
            step();
            #1;
            check($sformatf("vec%0d_grant_valid", v), grant_valid, 1);
            check($sformatf("vec%0d_grant_idx", v), grant_idx, 64'(vecs[v].exp));
            check($sformatf("vec%0d_out_valid", v), out_valid, 1);
        end

        // Round-robin rotation with 2-flit packets from everyone.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) add_pkt(i, 2, 1'b1, 0, 1'b1);
        add_pkt(0, 2, 1'b1, 1, 1'b1);
        drive();
        run_until_empty(200, ncyc);
        check("rr_cycles", 64'(ncyc), 18);
        check("rr_ngrants", 64'(glog.size()), 6);
        for (int k = 0; k < 6 && k < glog.size(); k++)
            check($sformatf("rr_order%0d", k), 64'(glog[k]), 64'(k % N));

        // Wormhole lock: input 1 holds through its 4-flit packet while input 3 waits.
        do_reset();
        onehot_viol = 0;
        add_pkt(1, 4, 1'b1, 0, 1'b1);
        add_pkt(3, 2, 1'b1, 0, 1'b1);
        drive();
        run_until_empty(100, ncyc);
        check("wh_cycles", 64'(ncyc), 8);
        check("wh_ready_only_holder", 64'(onehot_viol), 0);

        // Backpressure on holder 4 mid-packet.
        do_reset();
        add_pkt(4, 4, 1'b1, 0, 1'b1);
        drive();
        step();
        step();
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_out_flit", out_flit, mk(4, 0, 2, 1'b0));
            check("bp_req_ready", req_ready, 0);
            check("bp_out_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        run_until_empty(20, ncyc);
        check("bp_resume_cycles", 64'(ncyc), 2);

        // Length policing: 20 flits without tail from input 0, input 1 waiting.
        do_reset();
        err_seen = 0;
        add_pkt(0, 20, 1'b0, 0, 1'b0);
        for (int k = 0; k < MAX_PKT; k++) exp_q.push_back(mk(0, 0, k, 1'b0));
        add_pkt(1, 1, 1'b1, 0, 1'b1);
        for (int k = MAX_PKT; k < 20; k++) exp_q.push_back(mk(0, 0, k, 1'b0));
        drive();
        run_until_empty(100, ncyc);
        check("pol_cycles", 64'(ncyc), 24);
        check("pol_err_pulses", 64'(err_seen), 1);
        check("pol_ngrants", 64'(glog.size()), 3);
        if (glog.size() == 3) begin
            check("pol_g0", 64'(glog[0]), 0);
            check("pol_g1", 64'(glog[1]), 1);
            check("pol_g2", 64'(glog[2]), 0);
        end
        step();
        step();
        step();
        #1;
        check("bubble_hold_valid", grant_valid, 1);
        check("bubble_hold_idx", grant_idx, 0);

        // Reset mid-packet from input 2.
        do_reset();
        add_pkt(2, 5, 1'b1, 0, 1'b0);
        exp_q.push_back(mk(2, 0, 0, 1'b0));
        exp_q.push_back(mk(2, 0, 1, 1'b0));
        drive();
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_cycle_ready", req_ready, 0);
        check("mid_rst_cycle_valid", out_valid, 0);
        step();
        rst = 1'b0;
        clear_src();
        drive();
        #1;
        check("mid_rst_grant_valid", grant_valid, 0);
        check("mid_rst_req_ready", req_ready, 0);
        glog.delete();
        add_pkt(0, 1, 1'b1, 1, 1'b1);
        add_pkt(2, 1, 1'b1, 1, 1'b1);
        drive();
        run_until_empty(50, ncyc);
        check("mid_rst_ngrants", 64'(glog.size()), 2);
        if (glog.size() == 2) begin
            check("mid_rst_first", 64'(glog[0]), 0);
            check("mid_rst_second", 64'(glog[1]), 2);
        end

        check("req_ready_onehot", 64'(onehot_viol), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
